// File: rtl/csr_mach_regs.sv
// csr_mach_regs: machine-mode CSR file with WARL legalisation,
// WB commit, 64-bit counters and trap / MRET updates.
module csr_mach_regs #(
    parameter int             RSZ         = 32,
    parameter logic [RSZ-1:0] HART_ID     = '0,
    parameter logic [RSZ-1:0] MISA_VAL    = 32'h4000_1100,
    parameter logic [RSZ-1:0] MTVEC_RESET = '0
) (
    input  logic           clk_in,
    input  logic           reset_n,
    input  logic [11:0]    csr_addr,
    output logic [RSZ-1:0] csr_rd_data,
    output logic           csr_avail,
    input  logic           nxt_csr_wr,
    input  logic [11:0]    nxt_csr_wr_addr,
    input  logic [RSZ-1:0] nxt_csr_wr_data,
    output logic [RSZ-1:0] nxt_csr_rd_data,
    input  logic           wb_csr_wr,
    input  logic [11:0]    wb_csr_wr_addr,
    input  logic [RSZ-1:0] wb_csr_wr_data,
    input  logic           instret,
    input  logic           trap_valid,
    input  logic [RSZ-1:0] trap_cause,
    input  logic [RSZ-1:0] trap_epc,
    input  logic [RSZ-1:0] trap_tval,
    input  logic           mret,
    input  logic           ext_irq,
    input  logic           tmr_irq,
    output logic [RSZ-1:0] mtvec_out,
    output logic [RSZ-1:0] mepc_out,
    output logic           irq_pending
);

    localparam int CW = 2 * RSZ;

    logic           st_mie_q, st_mie_d;
    logic           st_mpie_q, st_mpie_d;
    logic [RSZ-1:0] mie_q, mie_d;
    logic           msip_q, msip_d;
    logic [RSZ-1:0] mtvec_q, mtvec_d;
    logic [RSZ-1:0] mscratch_q, mscratch_d;
    logic [RSZ-1:0] mepc_q, mepc_d;
    logic [RSZ-1:0] mcause_q, mcause_d;
    logic [RSZ-1:0] mtval_q, mtval_d;
    logic [CW-1:0]  mcycle_q, mcycle_d;
    logic [CW-1:0]  minstret_q, minstret_d;

    logic [RSZ-1:0] mstatus_v;
    logic [RSZ-1:0] mip_v;
    logic [RSZ-1:0] wb_val;

    // Architectural views of mstatus and mip assembled from stored bits
    always_comb begin
        mstatus_v        = '0;
        mstatus_v[12:11] = 2'b11;
        mstatus_v[7]     = st_mpie_q;
        mstatus_v[3]     = st_mie_q;
        mip_v            = '0;
        mip_v[11]        = ext_irq;
        mip_v[7]         = tmr_irq;
        mip_v[3]         = msip_q;
    end

    function automatic logic read_hit(input logic [11:0] a);
        case (a)
            12'h300, 12'h301, 12'h304, 12'h305,
            12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
            12'hB00, 12'hB02, 12'hB80, 12'hB82,
            12'hC00, 12'hC02, 12'hC80, 12'hC82,
            12'hF14: read_hit = 1'b1;
            default: read_hit = 1'b0;
        endcase
    endfunction

    function automatic logic [RSZ-1:0] read_data(input logic [11:0] a);
        case (a)
            12'h300:          read_data = mstatus_v;
            12'h301:          read_data = MISA_VAL;
            12'h304:          read_data = mie_q;
            12'h305:          read_data = mtvec_q;
            12'h340:          read_data = mscratch_q;
            12'h341:          read_data = mepc_q;
            12'h342:          read_data = mcause_q;
            12'h343:          read_data = mtval_q;
            12'h344:          read_data = mip_v;
            12'hB00, 12'hC00: read_data = mcycle_q[RSZ-1:0];
            12'hB80, 12'hC80: read_data = mcycle_q[CW-1:RSZ];
            12'hB02, 12'hC02: read_data = minstret_q[RSZ-1:0];
            12'hB82, 12'hC82: read_data = minstret_q[CW-1:RSZ];
            12'hF14:          read_data = HART_ID;
            default:          read_data = '0;
        endcase
    endfunction

    // Value the CSR would hold after a write of d; read-only and
    // unimplemented addresses keep their current read value.
    function automatic logic [RSZ-1:0] legal_csr(
        input logic [11:0]    a,
        input logic [RSZ-1:0] d
    );
        legal_csr = read_data(a);
        case (a)
            12'h300: legal_csr = (d & RSZ'(32'h88)) | RSZ'(32'h1800);
            12'h304: legal_csr = d & RSZ'(32'h888);
            12'h305: begin
                legal_csr = d;
                if (d[1]) legal_csr[1:0] = mtvec_q[1:0];
            end
            12'h341: legal_csr = d & ~RSZ'(3);
            12'h344: legal_csr[3] = d[3];
            12'h340, 12'h342, 12'h343,
            12'hB00, 12'hB02, 12'hB80, 12'hB82: legal_csr = d;
            default: ;
        endcase
    endfunction

    // EXE lookup, next-value query and interrupt request
    always_comb begin
        csr_avail       = read_hit(csr_addr);
        csr_rd_data     = read_data(csr_addr);
        nxt_csr_rd_data = read_data(nxt_csr_wr_addr);
        if (nxt_csr_wr)
            nxt_csr_rd_data = legal_csr(nxt_csr_wr_addr, nxt_csr_wr_data);
        irq_pending = st_mie_q & (|(mie_q & mip_v));
        mtvec_out   = mtvec_q;
        mepc_out    = mepc_q;
    end

    // Next state: counters, then WB commit, then MRET, then trap
    always_comb begin
        st_mie_d   = st_mie_q;
        st_mpie_d  = st_mpie_q;
        mie_d      = mie_q;
        msip_d     = msip_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mcycle_d   = mcycle_q + CW'(1);
        minstret_d = minstret_q + CW'(instret);
        wb_val     = legal_csr(wb_csr_wr_addr, wb_csr_wr_data);
        if (wb_csr_wr) begin
            case (wb_csr_wr_addr)
                12'h300: begin
                    st_mie_d  = wb_val[3];
                    st_mpie_d = wb_val[7];
                end
                12'h304: mie_d      = wb_val;
                12'h305: mtvec_d    = wb_val;
                12'h340: mscratch_d = wb_val;
                12'h341: mepc_d     = wb_val;
                12'h342: mcause_d   = wb_val;
                12'h343: mtval_d    = wb_val;
                12'h344: msip_d     = wb_val[3];
                12'hB00: mcycle_d   = {mcycle_q[CW-1:RSZ], wb_val};
                12'hB80: mcycle_d   = {wb_val, mcycle_q[RSZ-1:0]};
                12'hB02: minstret_d = {minstret_q[CW-1:RSZ], wb_val};
                12'hB82: minstret_d = {wb_val, minstret_q[RSZ-1:0]};
                default: ;
            endcase
        end
        if (mret) begin
            st_mie_d  = st_mpie_q;
            st_mpie_d = 1'b1;
        end
        if (trap_valid) begin
            st_mpie_d = st_mie_q;
            st_mie_d  = 1'b0;
            mepc_d    = trap_epc & ~RSZ'(3);
            mcause_d  = trap_cause;
            mtval_d   = trap_tval;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            st_mie_q   <= 1'b0;
            st_mpie_q  <= 1'b0;
            mie_q      <= '0;
            msip_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            st_mie_q   <= st_mie_d;
            st_mpie_q  <= st_mpie_d;
            mie_q      <= mie_d;
            msip_q     <= msip_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

endmodule

// File: tb/tb_csr_mach_regs.sv
// tb_csr_mach_regs: table vectors, directed corner sequences and
// random stimulus against a behavioural CSR model.
module tb_csr_mach_regs;

    logic        clk_in = 1'b0;
    logic        reset_n;
    logic [11:0] csr_addr;
    logic [31:0] csr_rd_data;
    logic        csr_avail;
    logic        nxt_csr_wr;
    logic [11:0] nxt_csr_wr_addr;
    logic [31:0] nxt_csr_wr_data;
    logic [31:0] nxt_csr_rd_data;
    logic        wb_csr_wr;
    logic [11:0] wb_csr_wr_addr;
    logic [31:0] wb_csr_wr_data;
    logic        instret;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_epc;
    logic [31:0] trap_tval;
    logic        mret;
    logic        ext_irq;
    logic        tmr_irq;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;
    logic        irq_pending;

    csr_mach_regs dut (
        .clk_in          (clk_in),
        .reset_n         (reset_n),
        .csr_addr        (csr_addr),
        .csr_rd_data     (csr_rd_data),
        .csr_avail       (csr_avail),
        .nxt_csr_wr      (nxt_csr_wr),
        .nxt_csr_wr_addr (nxt_csr_wr_addr),
        .nxt_csr_wr_data (nxt_csr_wr_data),
        .nxt_csr_rd_data (nxt_csr_rd_data),
        .wb_csr_wr       (wb_csr_wr),
        .wb_csr_wr_addr  (wb_csr_wr_addr),
        .wb_csr_wr_data  (wb_csr_wr_data),
        .instret         (instret),
        .trap_valid      (trap_valid),
        .trap_cause      (trap_cause),
        .trap_epc        (trap_epc),
        .trap_tval       (trap_tval),
        .mret            (mret),
        .ext_irq         (ext_irq),
        .tmr_irq         (tmr_irq),
        .mtvec_out       (mtvec_out),
        .mepc_out        (mepc_out),
        .irq_pending     (irq_pending)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Behavioural model: whole-word registers, 64-bit counters
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch;
    logic [31:0] m_mepc, m_mcause, m_mtval;
    logic        m_msip;
    logic [63:0] m_cyc, m_ret;

    task automatic model_reset();
        m_mstatus  = 32'h1800;
        m_mie      = 32'h0;
        m_mtvec    = 32'h0;
        m_mscratch = 32'h0;
        m_mepc     = 32'h0;
        m_mcause   = 32'h0;
        m_mtval    = 32'h0;
        m_msip     = 1'b0;
        m_cyc      = 64'h0;
        m_ret      = 64'h0;
    endtask

    function automatic logic [31:0] m_mip();
        return (ext_irq ? 32'h800 : 32'h0) | (tmr_irq ? 32'h80 : 32'h0)
             | (m_msip ? 32'h8 : 32'h0);
    endfunction

    function automatic logic [32:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return {1'b1, m_mstatus};
            12'h301: return {1'b1, 32'h4000_1100};
            12'h304: return {1'b1, m_mie};
            12'h305: return {1'b1, m_mtvec};
            12'h340: return {1'b1, m_mscratch};
            12'h341: return {1'b1, m_mepc};
            12'h342: return {1'b1, m_mcause};
            12'h343: return {1'b1, m_mtval};
            12'h344: return {1'b1, m_mip()};
            12'hB00, 12'hC00: return {1'b1, m_cyc[31:0]};
            12'hB80, 12'hC80: return {1'b1, m_cyc[63:32]};
            12'hB02, 12'hC02: return {1'b1, m_ret[31:0]};
            12'hB82, 12'hC82: return {1'b1, m_ret[63:32]};
            12'hF14: return {1'b1, 32'h0};
            default: return 33'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_nxt(input logic [11:0] a,
                                          input logic [31:0] d);
        logic [32:0] r;
        r = m_read(a);
        case (a)
            12'h300: return 32'h1800 | (d & 32'h88);
            12'h304: return d & 32'h888;
            12'h305: return (d[1:0] >= 2'd2)
                          ? ((d & ~32'h3) | (m_mtvec & 32'h3)) : d;
            12'h341: return d & ~32'h3;
            12'h344: return (r[31:0] & ~32'h8) | (d & 32'h8);
            12'h340, 12'h342, 12'h343,
            12'hB00, 12'hB02, 12'hB80, 12'hB82: return d;
            default: return r[31:0];
        endcase
    endfunction

    task automatic model_commit();
        logic [31:0] v;
        logic        w;
        logic [11:0] a;
        v = m_nxt(wb_csr_wr_addr, wb_csr_wr_data);
        w = wb_csr_wr;
        a = wb_csr_wr_addr;
        if (trap_valid) begin
            m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
            m_mepc    = trap_epc & ~32'h3;
            m_mcause  = trap_cause;
            m_mtval   = trap_tval;
        end else if (mret) begin
            m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
        end
        if (w) begin
            case (a)
                12'h300: if (!trap_valid && !mret) m_mstatus = v;
                12'h341: if (!trap_valid) m_mepc = v;
                12'h342: if (!trap_valid) m_mcause = v;
                12'h343: if (!trap_valid) m_mtval = v;
                12'h304: m_mie = v;
                12'h305: m_mtvec = v;
                12'h340: m_mscratch = v;
                12'h344: m_msip = v[3];
                default: ;
            endcase
        end
        if (w && a == 12'hB00) m_cyc = {m_cyc[63:32], v};
        else if (w && a == 12'hB80) m_cyc = {v, m_cyc[31:0]};
        else m_cyc = m_cyc + 64'd1;
        if (w && a == 12'hB02) m_ret = {m_ret[63:32], v};
        else if (w && a == 12'hB82) m_ret = {v, m_ret[31:0]};
        else m_ret = m_ret + (instret ? 64'd1 : 64'd0);
    endtask

    // Model advances on every clock edge outside reset
    initial begin
        forever begin
            @(posedge clk_in);
            if (reset_n) model_commit();
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] exp,
                      input string nm);
        csr_addr = a;
        #1;
        chk(nm, csr_rd_data, exp);
    endtask

    task automatic wb(input logic [11:0] a, input logic [31:0] d);
        wb_csr_wr      = 1'b1;
        wb_csr_wr_addr = a;
        wb_csr_wr_data = d;
    endtask

    task automatic check_model(input string tag);
        logic [32:0] r;
        logic [31:0] en;
        r  = m_read(csr_addr);
        en = nxt_csr_wr ? m_nxt(nxt_csr_wr_addr, nxt_csr_wr_data)
                        : m_nxt_raw(nxt_csr_wr_addr);
        chk({tag, " rd"}, csr_rd_data, r[31:0]);
        chk({tag, " avail"}, {31'b0, csr_avail}, {31'b0, r[32]});
        chk({tag, " nxt"}, nxt_csr_rd_data, en);
        chk({tag, " irq"}, {31'b0, irq_pending},
            {31'b0, m_mstatus[3] && ((m_mie & m_mip()) != 0)});
        chk({tag, " mtvec"}, mtvec_out, m_mtvec);
        chk({tag, " mepc"}, mepc_out, m_mepc);
    endtask

    function automatic logic [31:0] m_nxt_raw(input logic [11:0] a);
        logic [32:0] r;
        r = m_read(a);
        return r[31:0];
    endfunction

    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        avail;
    } vec_t;

    vec_t        tbl[14];
    logic [11:0] alist[18];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{12'h300, 32'hFFFF_FFFF, 32'h0000_1888, 1'b1};
        tbl[1]  = '{12'h300, 32'h0000_0000, 32'h0000_1800, 1'b1};
        tbl[2]  = '{12'h304, 32'hFFFF_FFFF, 32'h0000_0888, 1'b1};
        tbl[3]  = '{12'h305, 32'h8000_0003, 32'h8000_0000, 1'b1};
        tbl[4]  = '{12'h305, 32'h1234_5671, 32'h1234_5671, 1'b1};
        tbl[5]  = '{12'h305, 32'hABCD_0002, 32'hABCD_0001, 1'b1};
        tbl[6]  = '{12'h340, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
        tbl[7]  = '{12'h341, 32'h0000_0123, 32'h0000_0120, 1'b1};
        tbl[8]  = '{12'h342, 32'h8000_000B, 32'h8000_000B, 1'b1};
        tbl[9]  = '{12'h343, 32'h0000_0055, 32'h0000_0055, 1'b1};
        tbl[10] = '{12'h344, 32'hFFFF_FFFF, 32'h0000_0008, 1'b1};
        tbl[11] = '{12'h301, 32'h0000_0000, 32'h4000_1100, 1'b1};
        tbl[12] = '{12'hF14, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        tbl[13] = '{12'h7C0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        alist = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                  12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80,
                  12'hB82, 12'hC00, 12'hC02, 12'hC80, 12'hC82, 12'hF14};

        reset_n = 1'b0;
        csr_addr = '0; nxt_csr_wr = 0; nxt_csr_wr_addr = '0;
        nxt_csr_wr_data = '0; wb_csr_wr = 0; wb_csr_wr_addr = '0;
        wb_csr_wr_data = '0; instret = 0; trap_valid = 0;
        trap_cause = '0; trap_epc = '0; trap_tval = '0; mret = 0;
        ext_irq = 0; tmr_irq = 0;
        model_reset();
        #12;
        reset_n = 1'b1;

        // Reset values
        rd(12'h300, 32'h1800, "rst mstatus");
        rd(12'h301, 32'h4000_1100, "rst misa");
        rd(12'hF14, 32'h0, "rst mhartid");
        rd(12'h7C0, 32'h0, "rst unimpl data");
        chk("rst unimpl avail", {31'b0, csr_avail}, 32'h0);
        chk("rst mtvec_out", mtvec_out, 32'h0);
        chk("rst irq", {31'b0, irq_pending}, 32'h0);
        tick();

        // WARL vectors: nxt query then WB commit and readback
        for (int i = 0; i < 14; i++) begin
            csr_addr        = tbl[i].addr;
            nxt_csr_wr      = 1'b1;
            nxt_csr_wr_addr = tbl[i].addr;
            nxt_csr_wr_data = tbl[i].wdata;
            #1;
            chk($sformatf("vec%0d nxt", i), nxt_csr_rd_data, tbl[i].exp);
            nxt_csr_wr = 1'b0;
            wb(tbl[i].addr, tbl[i].wdata);
            tick();
            wb_csr_wr = 1'b0;
            #1;
            chk($sformatf("vec%0d rd", i), csr_rd_data, tbl[i].exp);
            chk($sformatf("vec%0d avail", i), {31'b0, csr_avail},
                {31'b0, tbl[i].avail});
        end
        chk("mtvec_out after vec", mtvec_out, 32'hABCD_0001);

        // Counter carry from low to high half
        wb(12'hB00, 32'hFFFF_FFFE);
        tick();
        wb(12'hB80, 32'h0);
        tick();
        wb_csr_wr = 1'b0;
        rd(12'hB00, 32'hFFFF_FFFE, "cyc held on high write");
        tick();
        tick();
        rd(12'hB00, 32'h0, "mcycle wrap");
        rd(12'hB80, 32'h1, "mcycleh carry");
        rd(12'hC00, 32'h0, "cycle mirror");
        rd(12'hC80, 32'h1, "cycleh mirror");

        // Interrupt pending and trap entry
        wb(12'h300, 32'h8);
        tick();
        wb(12'h304, 32'h80);
        tick();
        wb_csr_wr = 1'b0;
        #1;
        chk("irq no source", {31'b0, irq_pending}, 32'h0);
        tmr_irq = 1'b1;
        #1;
        chk("irq tmr", {31'b0, irq_pending}, 32'h1);
        rd(12'h344, 32'h88, "mip live");
        trap_valid = 1'b1;
        trap_cause = 32'h8000_0007;
        trap_epc   = 32'h123;
        trap_tval  = 32'h0;
        tick();
        trap_valid = 1'b0;
        #1;
        chk("trap mepc_out", mepc_out, 32'h120);
        chk("trap irq off", {31'b0, irq_pending}, 32'h0);
        rd(12'h300, 32'h1880, "trap mstatus");
        rd(12'h342, 32'h8000_0007, "trap mcause");

        // Trap beats MRET and a same-register WB write
        trap_valid = 1'b1; mret = 1'b1;
        trap_cause = 32'h2; trap_epc = 32'h207; trap_tval = 32'h99;
        wb(12'h341, 32'h40);
        tick();
        trap_valid = 1'b0; mret = 1'b0; wb_csr_wr = 1'b0;
        #1;
        chk("prio mepc", mepc_out, 32'h204);
        rd(12'h300, 32'h1800, "prio mstatus");
        rd(12'h342, 32'h2, "prio mcause");
        rd(12'h343, 32'h99, "prio mtval");
        trap_valid = 1'b1;
        trap_cause = 32'h3; trap_epc = 32'h8; trap_tval = 32'h0;
        wb(12'h340, 32'h77);
        tick();
        trap_valid = 1'b0; wb_csr_wr = 1'b0;
        rd(12'h340, 32'h77, "unrelated wb commits");
        chk("trap2 mepc", mepc_out, 32'h8);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        rd(12'h300, 32'h1880, "mret mpie set");
        mret = 1'b1;
        wb(12'h300, 32'h0);
        tick();
        mret = 1'b0; wb_csr_wr = 1'b0;
        rd(12'h300, 32'h1888, "mret beats wb");
        chk("irq after mret", {31'b0, irq_pending}, 32'h1);
        tmr_irq = 1'b0;

        // Retire coinciding with minstret write
        instret = 1'b1;
        wb(12'hB02, 32'h5);
        tick();
        wb_csr_wr = 1'b0;
        rd(12'hB02, 32'h5, "minstret write wins");
        tick();
        instret = 1'b0;
        rd(12'hB02, 32'h6, "minstret retire");
        rd(12'hC02, 32'h6, "instret mirror");

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            csr_addr = ($urandom_range(0, 7) == 0)
                     ? 12'($urandom) : alist[$urandom_range(0, 17)];
            nxt_csr_wr      = ($urandom_range(0, 1) == 1);
            nxt_csr_wr_addr = alist[$urandom_range(0, 17)];
            nxt_csr_wr_data = $urandom;
            wb_csr_wr       = ($urandom_range(0, 1) == 1);
            wb_csr_wr_addr  = ($urandom_range(0, 9) == 0)
                            ? 12'($urandom) : alist[$urandom_range(0, 17)];
            wb_csr_wr_data  = ($urandom_range(0, 3) == 0)
                            ? 32'hFFFF_FFFE : $urandom;
            instret    = ($urandom_range(0, 1) == 1);
            trap_valid = ($urandom_range(0, 15) == 0);
            mret       = ($urandom_range(0, 7) == 0);
            trap_cause = $urandom;
            trap_epc   = $urandom;
            trap_tval  = $urandom;
            ext_irq    = ($urandom_range(0, 3) == 0);
            tmr_irq    = ($urandom_range(0, 3) == 0);
            #1;
            check_model($sformatf("rnd%0d", i));
            tick();
        end

        // Asynchronous reset in the middle of a cycle
        wb_csr_wr = 0; trap_valid = 0; mret = 0; instret = 0;
        nxt_csr_wr = 0; ext_irq = 0; tmr_irq = 0;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("areset mepc_out", mepc_out, 32'h0);
        chk("areset mtvec_out", mtvec_out, 32'h0);
        rd(12'h300, 32'h1800, "areset mstatus");
        rd(12'hB00, 32'h0, "areset mcycle");
        @(negedge clk_in);
        reset_n = 1'b1;
        tick();
        rd(12'hB00, 32'h1, "mcycle after release");
        rd(12'hB02, 32'h0, "minstret after release");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
